// File: rtl/flex_pts_frame_tx.sv
// Framed parallel-to-serial transmitter: idle-high line, start bit (0), NUM_BITS data bits, STOP_BITS stop bits (1).
// Words are accepted on tx_valid & tx_ready and captured in a shift register for the whole frame.
module flex_pts_frame_tx #(
    parameter int NUM_BITS     = 32,
    parameter int SHIFT_MSB    = 1,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                busy,
    output logic                done
);

    localparam int PW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(NUM_BITS + STOP_BITS) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PRE_ONE   = PW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NUM_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    logic [1:0]          state_q, state_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [PW-1:0]       prescale_q, prescale_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;
    logic                accept;

    assign tx_ready = (state_q == IDLE) & ~rst;
    assign accept   = tx_valid & tx_ready;
    assign bit_end  = (prescale_q == PRE_LAST);

    // Both counters reload to zero on every state change, so they never wrap inside a state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        prescale_d = prescale_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = tx_data;
                    state_d    = START;
                    prescale_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    prescale_d = '0;
                end else begin
                    prescale_d = prescale_q + PRE_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    prescale_d = '0;
                    shift_d    = (SHIFT_MSB != 0) ? (shift_q << 1) : (shift_q >> 1);
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    prescale_d = prescale_q + PRE_ONE;
                end
            end
            default: begin
                if (bit_end) begin
                    prescale_d = '0;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    prescale_d = prescale_q + PRE_ONE;
                end
            end
        endcase
    end

    // Line level is decoded from the next state so serial_out is a plain flop.
    always_comb begin
        serial_d = 1'b1;
        if (state_d == START) begin
            serial_d = 1'b0;
        end else if (state_d == DATA) begin
            serial_d = (SHIFT_MSB != 0) ? shift_d[NUM_BITS-1] : shift_d[0];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            prescale_q <= '0;
            bit_cnt_q  <= '0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            prescale_q <= prescale_d;
            bit_cnt_q  <= bit_cnt_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_flex_pts_frame_tx.sv
// Directed bench for flex_pts_frame_tx: three instances cover MSB-first, LSB-first and
// single-clock-per-bit / two-stop-bit configurations, all with 8-bit words.
module tb_flex_pts_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_v [3];
    logic [2:0] valid_v;
    logic [2:0] ready_v;
    logic [2:0] serial_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    flex_pts_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut_msb (
        .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
        .serial_out(serial_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    flex_pts_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(2), .STOP_BITS(1)) dut_lsb (
        .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
        .serial_out(serial_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    flex_pts_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(1), .STOP_BITS(2)) dut_fast (
        .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
        .serial_out(serial_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a word at a falling edge; the next rising edge accepts it. Returns at the
    // falling edge of frame cycle 1 with tx_valid dropped.
    task automatic applyStimulus(input int inst, input logic [7:0] word);
        @(negedge clk);
        checkOutput("ready_before_send", {7'd0, ready_v[inst]}, 8'd1);
        data_v[inst]  = word;
        valid_v[inst] = 1'b1;
        @(negedge clk);
        valid_v[inst] = 1'b0;
    endtask

    // Starts at frame cycle 1; checks the line each cycle and rebuilds the word as a receiver would.
    task automatic checkFrame(input int inst, input logic [7:0] word, input int cpb, input int stops,
                              input bit msb, input bit toggle);
        int         nbits;
        int         pos;
        logic       exp_bit;
        logic [7:0] rx_word;
        nbits   = 1 + 8 + stops;
        rx_word = 8'h00;
        for (int k = 1; k <= nbits * cpb; k++) begin
            if (k > 1) @(negedge clk);
            pos = (k - 1) / cpb;
            if (pos == 0) exp_bit = 1'b0;
            else if (pos <= 8) exp_bit = msb ? word[8 - pos] : word[pos - 1];
            else exp_bit = 1'b1;
            checkOutput($sformatf("line_i%0d_c%0d", inst, k), {7'd0, serial_v[inst]}, {7'd0, exp_bit});
            checkOutput($sformatf("busy_i%0d_c%0d", inst, k), {7'd0, busy_v[inst]}, 8'd1);
            checkOutput($sformatf("done_low_i%0d_c%0d", inst, k), {7'd0, done_v[inst]}, 8'd0);
            if (pos >= 1 && pos <= 8 && ((k - 1) % cpb) == 0) begin
                if (msb) rx_word[8 - pos] = serial_v[inst];
                else     rx_word[pos - 1] = serial_v[inst];
            end
            if (toggle) data_v[inst] = 8'($urandom);
        end
        checkOutput($sformatf("rx_word_i%0d", inst), rx_word, word);
    endtask

    // Moves to the first IDLE cycle after STOP and checks the done pulse.
    task automatic finishFrame(input int inst);
        @(negedge clk);
        checkOutput("done_pulse", {7'd0, done_v[inst]}, 8'd1);
        checkOutput("ready_at_done", {7'd0, ready_v[inst]}, 8'd1);
        checkOutput("line_idle_at_done", {7'd0, serial_v[inst]}, 8'd1);
        checkOutput("busy_at_done", {7'd0, busy_v[inst]}, 8'd0);
        @(negedge clk);
        checkOutput("done_cleared", {7'd0, done_v[inst]}, 8'd0);
        checkOutput("line_idle_after", {7'd0, serial_v[inst]}, 8'd1);
    endtask

    initial begin
        valid_v = 3'b000;
        for (int i = 0; i < 3; i++) data_v[i] = 8'h00;

        // Reset, then ten idle cycles
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_line_i%0d", i), {7'd0, serial_v[i]}, 8'd1);
            checkOutput($sformatf("rst_busy_i%0d", i), {7'd0, busy_v[i]}, 8'd0);
            checkOutput($sformatf("rst_done_i%0d", i), {7'd0, done_v[i]}, 8'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("idle_line_i%0d", i), {7'd0, serial_v[i]}, 8'd1);
            checkOutput($sformatf("idle_ready_i%0d", i), {7'd0, ready_v[i]}, 8'd1);
            checkOutput($sformatf("idle_busy_i%0d", i), {7'd0, busy_v[i]}, 8'd0);
            checkOutput($sformatf("idle_done_i%0d", i), {7'd0, done_v[i]}, 8'd0);
        end

        $display("[TB] MSB-first 8'hA5, 2 clocks per bit");
        applyStimulus(0, 8'hA5);
        checkFrame(0, 8'hA5, 2, 1, 1'b1, 1'b0);
        finishFrame(0);

        $display("[TB] LSB-first 8'hA5, 2 clocks per bit");
        applyStimulus(1, 8'hA5);
        checkFrame(1, 8'hA5, 2, 1, 1'b0, 1'b0);
        finishFrame(1);

        $display("[TB] Back-to-back 8'h01 then 8'h80");
        @(negedge clk);
        data_v[0]  = 8'h01;
        valid_v[0] = 1'b1;
        @(negedge clk);
        data_v[0] = 8'h80;
        checkFrame(0, 8'h01, 2, 1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("b2b_done", {7'd0, done_v[0]}, 8'd1);
        checkOutput("b2b_ready", {7'd0, ready_v[0]}, 8'd1);
        @(negedge clk);
        valid_v[0] = 1'b0;
        checkFrame(0, 8'h80, 2, 1, 1'b1, 1'b0);
        finishFrame(0);

        $display("[TB] Reset in the middle of DATA");
        applyStimulus(0, 8'h3C);
        repeat (5) @(negedge clk);
        checkOutput("pre_abort_busy", {7'd0, busy_v[0]}, 8'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_line", {7'd0, serial_v[0]}, 8'd1);
        checkOutput("abort_busy", {7'd0, busy_v[0]}, 8'd0);
        checkOutput("abort_done", {7'd0, done_v[0]}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", {7'd0, ready_v[0]}, 8'd1);
        checkOutput("abort_line_after", {7'd0, serial_v[0]}, 8'd1);
        applyStimulus(0, 8'hC3);
        checkFrame(0, 8'hC3, 2, 1, 1'b1, 1'b0);
        finishFrame(0);

        $display("[TB] 1 clock per bit, 2 stop bits, tx_data toggling");
        applyStimulus(2, 8'hFF);
        checkFrame(2, 8'hFF, 1, 2, 1'b1, 1'b1);
        finishFrame(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
